// File: rtl/fft_buf_pkg.sv
// Shared constants, peak-hold FSM states and bank-rotation helper for the
// FFT spectrum frame buffer.
package fft_buf_pkg;

  localparam int         NBANK     = 3;
  localparam logic [1:0] BANK_NONE = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } pk_state_e;

  // Lowest-numbered bank that is neither the ready bank nor the locked bank.
  function automatic logic [1:0] next_free_bank(input logic [1:0] ready,
                                                input logic [1:0] lock);
    logic [1:0] pick;
    pick = 2'd0;
    for (int b = NBANK - 1; b >= 0; b--) begin
      if ((2'(b) != ready) && (2'(b) != lock)) pick = 2'(b);
    end
    return pick;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module sdp_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 12,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/fft_spectrum_buf.sv
// Triple-buffered FFT spectrum frame store with length checking, display
// readout (latency 2) and optional peak-hold with exponential decay.
module fft_spectrum_buf
  import fft_buf_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int FFT_LEN     = 256,
  parameter int DISP_LEN    = 128,
  parameter int DECAY_SHIFT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         fft_data,
  input  logic                      fft_valid,
  input  logic                      fft_sop,
  input  logic                      fft_eop,
  input  logic                      rd_frame_start,
  input  logic                      rd_req,
  input  logic                      peak_en,
  input  logic                      hold_clr,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic [$clog2(DISP_LEN):0] rd_point_cnt,
  output logic                      frame_ready,
  output logic                      frame_err
);

  localparam int IW  = $clog2(FFT_LEN) + 1;
  localparam int DAW = $clog2(DISP_LEN);
  localparam int PW  = DAW + 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(FFT_LEN - 1);
  localparam logic [IW-1:0]  FULL_IDX = IW'(FFT_LEN);
  localparam logic [IW-1:0]  DISP_IDX = IW'(DISP_LEN);
  localparam logic [PW-1:0]  DISP_CNT = PW'(DISP_LEN);
  localparam logic [DAW-1:0] CLR_LAST = DAW'(DISP_LEN - 1);

  function automatic logic [DATA_W-1:0] peak_decay_max(input logic [DATA_W-1:0] live,
                                                       input logic [DATA_W-1:0] hold);
    logic [DATA_W-1:0] decayed;
    decayed = hold - (hold >> DECAY_SHIFT);
    return (live > decayed) ? live : decayed;
  endfunction

  logic [IW-1:0]     wr_idx_q, wr_idx_eff;
  logic [1:0]        wr_bank_q, ready_bank_q, lock_bank_q, lock_bank_d;
  logic              frame_ready_q, frame_err_q;
  logic [PW-1:0]     rd_cnt_q;
  logic              wr_store, eop_beat, frame_good;
  logic              rd_fire, rd_zero;
  logic              vld_p1_q, zero_p1_q, pken_p1_q;
  logic [DAW-1:0]    idx_p1_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] live_data, hold_data, hold_eff, peak_out;
  pk_state_e         pk_state_q, pk_state_d;
  logic [DAW-1:0]    clr_addr_q, clr_addr_d;
  logic              pk_clearing, pk_wb, pk_we;
  logic [DAW-1:0]    pk_waddr;
  logic [DATA_W-1:0] pk_wdata;

  assign wr_idx_eff  = fft_sop ? '0 : wr_idx_q;
  assign wr_store    = fft_valid && (wr_idx_eff < DISP_IDX);
  assign eop_beat    = fft_valid && fft_eop;
  assign frame_good  = eop_beat && (wr_idx_eff == LAST_IDX);
  // A lock taken in the same cycle a frame completes sees the previous ready bank.
  assign lock_bank_d = rd_frame_start ? ready_bank_q : lock_bank_q;

  assign rd_fire = rd_req && !rd_frame_start;
  assign rd_zero = (rd_cnt_q == DISP_CNT) || (lock_bank_q == BANK_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q      <= '0;
      wr_bank_q     <= 2'd0;
      ready_bank_q  <= BANK_NONE;
      lock_bank_q   <= BANK_NONE;
      frame_ready_q <= 1'b0;
      frame_err_q   <= 1'b0;
      rd_cnt_q      <= '0;
    end else begin
      lock_bank_q <= lock_bank_d;
      frame_err_q <= eop_beat && !frame_good;
      if (fft_valid) begin
        if (fft_eop)                     wr_idx_q <= '0;
        else if (wr_idx_eff != FULL_IDX) wr_idx_q <= wr_idx_eff + 1'b1;
        else                             wr_idx_q <= wr_idx_eff;
      end
      if (frame_good) begin
        ready_bank_q  <= wr_bank_q;
        frame_ready_q <= 1'b1;
        wr_bank_q     <= next_free_bank(wr_bank_q, lock_bank_d);
      end
      if (rd_frame_start)                     rd_cnt_q <= '0;
      else if (rd_req && rd_cnt_q != DISP_CNT) rd_cnt_q <= rd_cnt_q + 1'b1;
    end
  end

  sdp_ram #(
    .ADDR_W (DAW + 2),
    .DATA_W (DATA_W),
    .DEPTH  (NBANK * DISP_LEN)
  ) u_bank_ram (
    .clk     (clk),
    .we_i    (wr_store),
    .waddr_i ({wr_bank_q, wr_idx_eff[DAW-1:0]}),
    .wdata_i (fft_data),
    .re_i    (rd_fire && !rd_zero),
    .raddr_i ({lock_bank_q, rd_cnt_q[DAW-1:0]}),
    .rdata_o (live_data)
  );

  sdp_ram #(
    .ADDR_W (DAW),
    .DATA_W (DATA_W),
    .DEPTH  (DISP_LEN)
  ) u_peak_ram (
    .clk     (clk),
    .we_i    (pk_we),
    .waddr_i (pk_waddr),
    .wdata_i (pk_wdata),
    .re_i    (rd_fire && !rd_zero),
    .raddr_i (rd_cnt_q[DAW-1:0]),
    .rdata_o (hold_data)
  );

  // Stage 1: RAM read in flight, request attributes travel alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      zero_p1_q <= 1'b0;
      pken_p1_q <= 1'b0;
    end else begin
      vld_p1_q  <= rd_fire;
      zero_p1_q <= rd_zero;
      pken_p1_q <= peak_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_fire) idx_p1_q <= rd_cnt_q[DAW-1:0];
  end

  // Stage 2: select live/peak value and write the new peak back.
  assign pk_clearing = (pk_state_q == CLEAR);
  assign hold_eff    = pk_clearing ? '0 : hold_data;
  assign peak_out    = peak_decay_max(live_data, hold_eff);
  assign rd_data_d   = zero_p1_q ? '0 : (pken_p1_q ? peak_out : live_data);
  assign pk_wb       = vld_p1_q && !zero_p1_q && pken_p1_q && !pk_clearing;
  assign pk_we       = pk_clearing || pk_wb;
  assign pk_waddr    = pk_clearing ? clr_addr_q : idx_p1_q;
  assign pk_wdata    = pk_clearing ? '0 : peak_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= vld_p1_q;
      if (vld_p1_q) rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_state_q <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      pk_state_q <= pk_state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    pk_state_d = pk_state_q;
    clr_addr_d = clr_addr_q;
    if (hold_clr) begin
      pk_state_d = CLEAR;
      clr_addr_d = '0;
    end else begin
      case (pk_state_q)
        CLEAR: begin
          if (clr_addr_q == CLR_LAST) begin
            pk_state_d = IDLE;
            clr_addr_d = '0;
          end else begin
            clr_addr_d = clr_addr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign rd_point_cnt = rd_cnt_q;
  assign frame_ready  = frame_ready_q;
  assign frame_err    = frame_err_q;

endmodule
